// File: rtl/pulse_event_launcher_pkg.sv
// Shared encodings and defaults for the pulse event launcher.
package pulse_event_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_FREE = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/pulse_event_launcher_sat_updown_counter.sv
// Saturating up/down counter holding the number of queued events.
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = '1;

  assign at_max = (count == MAX);

  // Simultaneous inc and dec cancel; neither end of the range ever wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_event_launcher.sv
// Queues single-cycle events and launches them one at a time into a
// handshake pulse synchronizer, waiting out each busy round trip.
module pulse_event_launcher
  import pulse_event_launcher_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt_in,
  input  logic             sync_busy,
  input  logic             clr_ovf,
  output logic             sync_in,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             idle
);

  // state     | meaning
  // IDLE      | nothing in flight; launch when pending!=0 and sync_busy low
  // ISSUE     | sync_in high for this one cycle; pending drops on exit
  // WAIT_BUSY | waiting for the synchronizer to report busy
  // WAIT_FREE | waiting for the synchronizer to go free again
  state_t state, state_next;
  logic   dec;
  logic   at_max;
  logic   ovf_set;

  assign dec     = (state == ISSUE);
  assign ovf_set = evt_in && !dec && at_max;

  sat_updown_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (evt_in),
    .dec    (dec),
    .count  (pending),
    .at_max (at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if ((pending != '0) && !sync_busy) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (sync_busy) state_next = WAIT_FREE;
      WAIT_FREE: if (!sync_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Registered copy of the ISSUE decode so the synchronizer sees a clean pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_in <= 1'b0;
    end else begin
      sync_in <= (state_next == ISSUE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign idle = (pending == '0) && (state == IDLE) && !sync_busy;

endmodule

// File: tb/tb_pulse_event_launcher.sv
// Scoreboard bench: accepted events are queued as ids and retired when the
// launcher's ISSUE cycle ends; the synchronizer is modelled as a busy timer.
module tb_pulse_event_launcher;

  localparam int CNT_W = 4;
  localparam int MAXP  = 15;
  localparam int GAP   = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             evt_in = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             busy_force = 1'b0;
  logic             sync_busy;
  logic             sync_in;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             idle;

  int hold = 0;

  always #5 clk = ~clk;

  // Downstream model: busy registered one cycle after sync_in, held 6 cycles,
  // and unaffected by the launcher's reset.
  always @(posedge clk) begin
    if (sync_in) hold <= 6;
    else if (hold != 0) hold <= hold - 1;
  end
  assign sync_busy = busy_force | (hold != 0);

  pulse_event_launcher #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .evt_in    (evt_in),
    .sync_busy (sync_busy),
    .clr_ovf   (clr_ovf),
    .sync_in   (sync_in),
    .pending   (pending),
    .overflow  (overflow),
    .idle      (idle)
  );

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int next_id = 0;
  int last_pop = -1;
  int order_err = 0;
  int underflow = 0;
  int double_pulse = 0;
  int launches = 0;
  int cyc = 0;
  int last_launch = 0;
  int last_gap = 0;
  bit exp_ovf = 1'b0;

  task automatic tick(input logic e, input logic c);
    logic prev_sync;
    bit   set;
    int   id;
    evt_in = e;
    clr_ovf = c;
    prev_sync = sync_in;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_sync) begin
      if (sb_q.size() == 0) underflow++;
      else begin
        id = sb_q.pop_front();
        if (id != last_pop + 1) order_err++;
        last_pop = id;
      end
    end
    set = e && (sb_q.size() == MAXP);
    if (e && !set) begin
      sb_q.push_back(next_id);
      next_id++;
    end
    if (set) exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    if (sync_in) begin
      launches++;
      last_gap = cyc - last_launch;
      last_launch = cyc;
      if (prev_sync) double_pulse++;
    end
    evt_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (idle && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pending, sync_in, overflow, idle} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got pend=%0d sync_in=%b ovf=%b idle=%b, expected 0 0 0 1",
               pending, sync_in, overflow, idle);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({pending, sync_in, overflow, idle} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_release[%0d]: got pend=%0d sync_in=%b ovf=%b idle=%b, expected 0 0 0 1",
                 i, pending, sync_in, overflow, idle);
      end
    end
  endtask

  task automatic test_single;
    int l0 = launches;
    int extra = 0;
    tick(1'b1, 1'b0);
    checks++;
    if ({pending, sync_in} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_e0: got pend=%0d sync_in=%b, expected 1 0", pending, sync_in);
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({pending, sync_in} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL single_e1: got pend=%0d sync_in=%b, expected 1 1", pending, sync_in);
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({pending, sync_in} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_e2: got pend=%0d sync_in=%b, expected 0 0", pending, sync_in);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      if (sync_in) extra++;
    end
    checks++;
    if (extra !== 0 || idle !== 1'b1 || (launches - l0) !== 1) begin
      errors++;
      $display("FAIL single_after: got extra=%0d idle=%b launches=%0d, expected 0 1 1",
               extra, idle, launches - l0);
    end
  endtask

  task automatic test_back_to_back;
    int l0 = launches;
    int peak = 0;
    bit done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (int'(pending) > peak) peak = int'(pending);
    end
    checks++;
    if (peak < 4 || peak > 5) begin
      errors++;
      $display("FAIL b2b_peak: got %0d, expected 4 or 5", peak);
    end
    for (int i = 0; i < 200; i++) begin
      if (idle && sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick(1'b0, 1'b0);
      checks++;
      if (int'(pending) !== sb_q.size()) begin
        errors++;
        $display("FAIL b2b_pending: got %0d, expected %0d", pending, sb_q.size());
      end
      if (sync_in && (launches - l0) >= 2) begin
        checks++;
        if (last_gap !== GAP) begin
          errors++;
          $display("FAIL b2b_gap: got %0d, expected %0d", last_gap, GAP);
        end
      end
    end
    checks++;
    if (!done || (launches - l0) !== 5 || pending !== 4'd0) begin
      errors++;
      $display("FAIL b2b_end: got done=%b launches=%0d pend=%0d, expected 1 5 0",
               done, launches - l0, pending);
    end
  endtask

  task automatic test_overflow;
    int l0 = launches;
    bit ok;
    busy_force = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(1'b1, 1'b0);
      if (i == 15) begin
        checks++;
        if ({pending, overflow} !== {4'd15, 1'b0}) begin
          errors++;
          $display("FAIL ovf_fill: got pend=%0d ovf=%b, expected 15 0", pending, overflow);
        end
      end
      if (i == 16) begin
        checks++;
        if ({pending, overflow} !== {4'd15, 1'b1}) begin
          errors++;
          $display("FAIL ovf_set: got pend=%0d ovf=%b, expected 15 1", pending, overflow);
        end
      end
    end
    checks++;
    if (overflow !== exp_ovf || launches !== l0) begin
      errors++;
      $display("FAIL ovf_hold: got ovf=%b launches=%0d, expected %b 0", overflow, launches - l0, exp_ovf);
    end
    tick(1'b1, 1'b1);
    checks++;
    if ({pending, overflow} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set_wins: got pend=%0d ovf=%b, expected 15 1", pending, overflow);
    end
    tick(1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_stays_clear: got %b, expected %b", overflow, exp_ovf);
    end
    busy_force = 1'b0;
    drain(ok);
    checks++;
    if (!ok || (launches - l0) !== 15 || pending !== 4'd0) begin
      errors++;
      $display("FAIL ovf_drain: got ok=%b launches=%0d pend=%0d, expected 1 15 0",
               ok, launches - l0, pending);
    end
  endtask

  task automatic test_coincident;
    int l0 = launches;
    logic [CNT_W-1:0] pre;
    bit ok;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (sync_in !== 1'b1) begin
      errors++;
      $display("FAIL coinc_issue: got sync_in=%b, expected 1", sync_in);
    end
    pre = pending;
    tick(1'b1, 1'b0);
    checks++;
    if (pending !== pre || int'(pending) !== sb_q.size()) begin
      errors++;
      $display("FAIL coinc_pending: got %0d, expected %0d", pending, pre);
    end
    drain(ok);
    checks++;
    if (!ok || (launches - l0) !== 2) begin
      errors++;
      $display("FAIL coinc_total: got ok=%b launches=%0d, expected 1 2", ok, launches - l0);
    end
  endtask

  task automatic test_reset_mid;
    int l0 = launches;
    int bad = 0;
    bit launched = 1'b0;
    bit busy_before;
    bit ok;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if ({pending, sync_busy, sync_in} !== {4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rmid_setup: got pend=%0d busy=%b sync_in=%b, expected 3 1 0",
               pending, sync_busy, sync_in);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({pending, sync_in, overflow} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_async: got pend=%0d sync_in=%b ovf=%b, expected 0 0 0",
               pending, sync_in, overflow);
    end
    sb_q.delete();
    last_pop = next_id - 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      busy_before = sync_busy;
      tick(1'b0, 1'b0);
      if (sync_in && busy_before) bad++;
      if (sync_in) begin
        launched = 1'b1;
        break;
      end
    end
    checks++;
    if (bad !== 0 || !launched) begin
      errors++;
      $display("FAIL rmid_wait_free: got bad=%0d launched=%b, expected 0 1", bad, launched);
    end
    drain(ok);
    checks++;
    if (!ok || (launches - l0) !== 2 || pending !== 4'd0) begin
      errors++;
      $display("FAIL rmid_end: got ok=%b launches=%0d pend=%0d, expected 1 2 0",
               ok, launches - l0, pending);
    end
  endtask

  task automatic test_integrity;
    checks++;
    if (underflow !== 0 || double_pulse !== 0 || order_err !== 0 || int'(pending) !== sb_q.size()) begin
      errors++;
      $display("FAIL integrity: got underflow=%0d double=%0d order=%0d pend=%0d sb=%0d, expected 0 0 0 equal",
               underflow, double_pulse, order_err, pending, sb_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_reset_mid();
    test_integrity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
